control_sequencer: RTL

//  - SAP-1 control unit: 6-state ring counter (T1..T6) plus microcode decode of the IR opcode.
//  - Drives the 12-bit control word {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo} that the top-level

---
 rtl/control_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// SAP-1 control sequencer: one-hot T1..T6 ring counter plus microcode decode of the IR opcode.
// Latency: con_word is combinational from the current T-state/opcode; state advances on each rising CLK.
// Backpressure: none in the default build; with SINGLE_STEP_EN the ring only advances while step is high.
//
// Optional feature macro: SINGLE_STEP_EN (adds the `step` input for level-qualified single stepping).
//
// Ports:
//   CLK        system clock, all state updates on the rising edge
//   CLR        synchronous reset, active-high; forces con_word to NOP_WORD while asserted
//   step       (SINGLE_STEP_EN only) advance one T-state per cycle sampled high
//   opcode     IR opcode (ir_out[7:4]); only decoded in T4..T6
//   con_word   control word {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
//   t_state    one-hot ring state, bit0=T1 .. bit5=T6
//   halted     set when HLT executes in T4, cleared only by CLR
//   instr_cnt  instructions retired since reset, counts on each T6->T1 transition
module control_sequencer #(
    parameter logic [11:0] NOP_WORD = 12'h3E3,
    parameter int          ICNT_W   = 8
) (
    input  logic              CLK,
    input  logic              CLR,
`ifdef SINGLE_STEP_EN
    input  logic              step,
`endif
    input  logic [3:0]        opcode,
    output logic [11:0]       con_word,
    output logic [5:0]        t_state,
    output logic              halted,
    output logic [ICNT_W-1:0] instr_cnt
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_e;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [11:0] W_FETCH1  = 12'h5E3;  // Ep, Lm
    localparam logic [11:0] W_FETCH2  = 12'hBE3;  // Cp
    localparam logic [11:0] W_FETCH3  = 12'h263;  // CE, Li
    localparam logic [11:0] W_IR_MAR  = 12'h1A3;  // Lm, Ei
    localparam logic [11:0] W_RAM_A   = 12'h2C3;  // CE, La
    localparam logic [11:0] W_RAM_B   = 12'h2E1;  // CE, Lb
    localparam logic [11:0] W_ADD_A   = 12'h3C7;  // La, Eu
    localparam logic [11:0] W_SUB_A   = 12'h3CF;  // La, Su, Eu
    localparam logic [11:0] W_A_OUT   = 12'h3F2;  // Ea, Lo

    tstate_e           state_q, state_d;
    logic              halted_q, halted_d;
    logic [ICNT_W-1:0] cnt_q, cnt_d;

    logic              advance;
    logic              run;
    logic              legal;
    logic [11:0]       word;
    tstate_e           nxt;
    logic              hlt_now;

`ifdef SINGLE_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    // The ring moves (and strobes fire) only when not halted and not paused.
    assign run = !halted_q && advance;

    // Microcode decode: word for the current T-state and the ring successor.
    always_comb begin
        word    = NOP_WORD;
        nxt     = T1;
        legal   = 1'b1;
        hlt_now = 1'b0;
        case (state_q)
            T1: begin word = W_FETCH1; nxt = T2; end
            T2: begin word = W_FETCH2; nxt = T3; end
            T3: begin word = W_FETCH3; nxt = T4; end
            T4: begin
                nxt = T5;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: word = W_IR_MAR;
                    OP_OUT:                 word = W_A_OUT;
                    OP_HLT: begin
                        // HLT parks the ring on T4 with nothing asserted.
                        word    = NOP_WORD;
                        nxt     = T4;
                        hlt_now = 1'b1;
                    end
                    default:                word = NOP_WORD;
                endcase
            end
            T5: begin
                nxt = T6;
                case (opcode)
                    OP_LDA:         word = W_RAM_A;
                    OP_ADD, OP_SUB: word = W_RAM_B;
                    default:        word = NOP_WORD;
                endcase
            end
            T6: begin
                nxt = T1;
                case (opcode)
                    OP_ADD:  word = W_ADD_A;
                    OP_SUB:  word = W_SUB_A;
                    default: word = NOP_WORD;
                endcase
            end
            default: begin
                word  = NOP_WORD;
                nxt   = T1;
                legal = 1'b0;
            end
        endcase
    end

    // Next-state and output gating.
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;
        con_word = NOP_WORD;
        if (!legal) begin
            // A corrupted ring recovers to T1 whatever else is going on.
            state_d = T1;
        end else if (run) begin
            con_word = word;
            state_d  = nxt;
            if (hlt_now) begin
                halted_d = 1'b1;
            end
            if (state_q == T6) begin
                cnt_d = cnt_q + ICNT_W'(1);
            end
        end
        if (CLR) begin
            con_word = NOP_WORD;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q  <= T1;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign t_state   = state_q;
    assign halted    = halted_q;
    assign instr_cnt = cnt_q;

endmodule
